branch_metric: RTL and testbench

BRANCH_METRIC -- requirements
Module: branch_metric

---
 rtl/branch_metric.sv | 167 ++++++++++++++++
 tb/tb_branch_metric.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_metric.sv
// Branch-metric unit for a turbo-decoder constituent SISO: scales the partner's
// extrinsic LLR and forms saturated a2 / a1s+a3 / a1s+a2+a3 metrics through a two-stage pipeline.
module branch_metric #(
  parameter int N        = 5,
  parameter int M        = 6,
  parameter int MAX_ITER = 8,
  localparam int IW      = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                nClear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [M-1:0] a1,
  input  logic signed [N-1:0] a2,
  input  logic signed [N-1:0] a3,
  input  logic                iter_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] ba2,
  output logic signed [M:0]   ba1ba3,
  output logic signed [M:0]   ba1ba2ba3,
  output logic [IW-1:0]       iter_count,
  output logic                frame_done
);

  // Three sign-extended operands of at most M bits never overflow M+2 bits.
  localparam int SW = M + 2;
  localparam logic [IW-1:0] LAST_ITER = IW'(MAX_ITER - 1);

  function automatic logic signed [M-1:0] scale_a1(input logic signed [M-1:0] x);
    return x - (x >>> 2'd2);
  endfunction

  function automatic logic signed [M:0] sat(input logic signed [SW-1:0] x);
    logic signed [M:0] r;
    if (x[SW-1] == x[SW-2]) begin
      r = x[M:0];
    end else if (x[SW-1]) begin
      r = {1'b1, {M{1'b0}}};
    end else begin
      r = {1'b0, {M{1'b1}}};
    end
    return r;
  endfunction

  logic                s1_valid_r;
  logic signed [M-1:0] s1_a1s_r;
  logic signed [N-1:0] s1_a2_r;
  logic signed [N-1:0] s1_a3_r;
  logic                out_valid_r;
  logic signed [N-1:0] ba2_r;
  logic signed [M:0]   ba1ba3_r;
  logic signed [M:0]   ba1ba2ba3_r;
  logic [IW-1:0]       iter_count_r;
  logic                frame_done_r;

  logic                s2_load_s;
  logic                s1_move_s;
  logic                s1_load_s;
  logic signed [SW-1:0] a1s_ext_s;
  logic signed [SW-1:0] a2_ext_s;
  logic signed [SW-1:0] a3_ext_s;
  logic signed [SW-1:0] sum13_s;
  logic signed [SW-1:0] sum123_s;

  // Handshake: each stage refills when empty or when its content moves on.
  assign s2_load_s = !out_valid_r || out_ready;
  assign s1_move_s = s1_valid_r && s2_load_s;
  assign s1_load_s = !s1_valid_r || s1_move_s;
  assign in_ready  = s1_load_s;

  // Widen S1 operands and form the raw sums ahead of saturation.
  always_comb begin
    a1s_ext_s = {{(SW-M){s1_a1s_r[M-1]}}, s1_a1s_r};
    a2_ext_s  = {{(SW-N){s1_a2_r[N-1]}}, s1_a2_r};
    a3_ext_s  = {{(SW-N){s1_a3_r[N-1]}}, s1_a3_r};
    sum13_s   = a1s_ext_s + a3_ext_s;
    sum123_s  = a1s_ext_s + a2_ext_s + a3_ext_s;
  end

  // Stage 1: capture the triple; the first half-iteration has no extrinsic input yet.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid_r <= 1'b0;
      s1_a1s_r   <= {M{1'b0}};
      s1_a2_r    <= {N{1'b0}};
      s1_a3_r    <= {N{1'b0}};
    end else if (!nClear) begin
      s1_valid_r <= 1'b0;
      s1_a1s_r   <= {M{1'b0}};
      s1_a2_r    <= {N{1'b0}};
      s1_a3_r    <= {N{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a1s_r <= (iter_count_r == {IW{1'b0}}) ? {M{1'b0}} : scale_a1(a1);
        s1_a2_r  <= a2;
        s1_a3_r  <= a3;
      end else begin
        s1_a1s_r <= s1_a1s_r;
        s1_a2_r  <= s1_a2_r;
        s1_a3_r  <= s1_a3_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: register the saturated metrics; data holds while stalled or bubbling.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      out_valid_r <= 1'b0;
      ba2_r       <= {N{1'b0}};
      ba1ba3_r    <= {(M+1){1'b0}};
      ba1ba2ba3_r <= {(M+1){1'b0}};
    end else if (!nClear) begin
      out_valid_r <= 1'b0;
      ba2_r       <= {N{1'b0}};
      ba1ba3_r    <= {(M+1){1'b0}};
      ba1ba2ba3_r <= {(M+1){1'b0}};
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        ba2_r       <= s1_a2_r;
        ba1ba3_r    <= sat(sum13_s);
        ba1ba2ba3_r <= sat(sum123_s);
      end else begin
        ba2_r       <= ba2_r;
        ba1ba3_r    <= ba1ba3_r;
        ba1ba2ba3_r <= ba1ba2ba3_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Half-iteration counter; frame_done marks the wrap one cycle later.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      iter_count_r <= {IW{1'b0}};
      frame_done_r <= 1'b0;
    end else if (!nClear) begin
      iter_count_r <= {IW{1'b0}};
      frame_done_r <= 1'b0;
    end else if (iter_done) begin
      if (iter_count_r == LAST_ITER) begin
        iter_count_r <= {IW{1'b0}};
        frame_done_r <= 1'b1;
      end else begin
        iter_count_r <= iter_count_r + IW'(1);
        frame_done_r <= 1'b0;
      end
    end else begin
      iter_count_r <= iter_count_r;
      frame_done_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign ba2        = ba2_r;
  assign ba1ba3     = ba1ba3_r;
  assign ba1ba2ba3  = ba1ba2ba3_r;
  assign iter_count = iter_count_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_branch_metric.sv
// Directed self-checking bench for branch_metric; a second N=M=6 instance
// shares the stimulus so the saturation corners are reachable.
module tb_branch_metric;

  localparam int N = 5;
  localparam int M = 6;
  localparam int MAX_ITER = 8;
  localparam int IW = $clog2(MAX_ITER);

  logic Clock = 1'b0;
  logic nReset, nClear, in_valid, iter_done, out_ready;
  logic signed [M-1:0] a1;
  logic signed [5:0] a2w, a3w;
  logic signed [N-1:0] a2, a3;

  logic in_ready, out_valid, frame_done;
  logic signed [N-1:0] ba2;
  logic signed [M:0] ba1ba3, ba1ba2ba3;
  logic [IW-1:0] iter_count;

  logic d6_in_ready, d6_out_valid, d6_frame_done;
  logic signed [5:0] d6_ba2;
  logic signed [6:0] d6_ba1ba3, d6_ba1ba2ba3;
  logic [IW-1:0] d6_iter_count;

  int tests_run = 0;
  int tests_failed = 0;

  assign a2 = a2w[N-1:0];
  assign a3 = a3w[N-1:0];

  always #5 Clock = ~Clock;

  branch_metric #(.N(N), .M(M), .MAX_ITER(MAX_ITER)) dut (
    .Clock(Clock), .nReset(nReset), .nClear(nClear),
    .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .a2(a2), .a3(a3), .iter_done(iter_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .ba2(ba2), .ba1ba3(ba1ba3), .ba1ba2ba3(ba1ba2ba3),
    .iter_count(iter_count), .frame_done(frame_done)
  );

  branch_metric #(.N(6), .M(6), .MAX_ITER(MAX_ITER)) dut6 (
    .Clock(Clock), .nReset(nReset), .nClear(nClear),
    .in_valid(in_valid), .in_ready(d6_in_ready),
    .a1(a1), .a2(a2w), .a3(a3w), .iter_done(iter_done),
    .out_valid(d6_out_valid), .out_ready(out_ready),
    .ba2(d6_ba2), .ba1ba3(d6_ba1ba3), .ba1ba2ba3(d6_ba1ba2ba3),
    .iter_count(d6_iter_count), .frame_done(d6_frame_done)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One triple with the consumer always ready; returns at the sample point 2 cycles on.
  task automatic push(input int v1, input int v2, input int v3, input logic it);
    @(negedge Clock);
    a1 = M'(v1); a2w = 6'(v2); a3w = 6'(v3);
    in_valid = 1'b1; out_ready = 1'b1; iter_done = it;
    check("push_in_ready", in_ready, 1'b1);
    @(posedge Clock); #1;
    in_valid = 1'b0; iter_done = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic pulse_iter();
    @(negedge Clock); iter_done = 1'b1;
    @(posedge Clock); #1; iter_done = 1'b0;
    @(negedge Clock);
  endtask

  // Fill both stages with the consumer stalled.
  task automatic fill_two();
    @(negedge Clock);
    out_ready = 1'b0; in_valid = 1'b1; a1 = 6'sd20; a2w = 6'sd10; a3w = -6'sd7;
    @(posedge Clock); #1; a2w = 6'sd3;
    @(posedge Clock); #1; in_valid = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    int tx, rx, occ;
    logic held_v, in_x, out_x;
    logic signed [M:0] held_s;

    nReset = 1'b0; nClear = 1'b1; in_valid = 1'b0; iter_done = 1'b0;
    out_ready = 1'b0; a1 = '0; a2w = '0; a3w = '0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ba2", ba2, 0);
    check("rst_ba1ba3", ba1ba3, 0);
    check("rst_ba1ba2ba3", ba1ba2ba3, 0);
    check("rst_iter_count", iter_count, 0);
    check("rst_frame_done", frame_done, 1'b0);
    @(negedge Clock); nReset = 1'b1;

    // Iteration 0, with iter_done coincident: a1s forced to 0.
    push(20, 10, -7, 1'b1);
    check("it0_valid", out_valid, 1'b1);
    check("it0_ba2", ba2, 10);
    check("it0_ba1ba3", ba1ba3, -7);
    check("it0_ba1ba2ba3", ba1ba2ba3, 3);
    check("it0_count_after", iter_count, 1);

    // Iteration 1: a1s = a1 - floor(a1/4).
    push(20, 10, -7, 1'b0);
    check("scale_ba1ba3", ba1ba3, 8);
    check("scale_ba1ba2ba3", ba1ba2ba3, 18);
    push(-21, 0, 0, 1'b0);
    check("scale_neg_ba1ba3", ba1ba3, -15);
    check("scale_neg_sum", ba1ba2ba3, -15);

    // Saturation on the N=M=6 instance.
    push(31, 31, 31, 1'b0);
    check("sat_hi_sum", d6_ba1ba2ba3, 63);
    check("sat_hi_ba1ba3", d6_ba1ba3, 55);
    check("sat_hi_ba2", d6_ba2, 31);
    push(-32, -32, -32, 1'b0);
    check("sat_lo_sum", d6_ba1ba2ba3, -64);
    check("sat_lo_ba1ba3", d6_ba1ba3, -56);

    // Backpressure stream at iteration 1: a1=4 -> a1s=3, triple k = (4, k, k-5).
    pat = 16'b1101_1010_0110_1000;
    tx = 0; rx = 0; occ = 0; held_v = 1'b0; held_s = '0;
    for (int cyc = 0; cyc < 200 && rx < 10; cyc++) begin
      @(negedge Clock);
      if (held_v) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", ba1ba2ba3, held_s);
      end
      out_ready = pat[cyc % 16];
      in_valid = (tx < 10);
      a1 = 6'sd4; a2w = 6'(tx); a3w = 6'(tx - 5);
      #1;
      check("bp_in_ready", in_ready, !(occ == 2 && !out_ready));
      in_x = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        check("bp_ba2", ba2, rx);
        check("bp_ba1ba3", ba1ba3, rx - 2);
        check("bp_ba1ba2ba3", ba1ba2ba3, 2 * rx - 2);
        rx++;
      end
      held_v = out_valid && !out_ready;
      held_s = ba1ba2ba3;
      if (in_x) tx++;
      occ = occ + (in_x ? 1 : 0) - (out_x ? 1 : 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", rx, 10);

    // Clear with both stages full; nClear overrides a coincident iter_done.
    fill_two();
    check("clr_full_valid", out_valid, 1'b1);
    check("clr_full_ready", in_ready, 1'b0);
    nClear = 1'b0; iter_done = 1'b1;
    @(posedge Clock); #1; nClear = 1'b1; iter_done = 1'b0;
    @(negedge Clock);
    check("clr_valid", out_valid, 1'b0);
    check("clr_ba2", ba2, 0);
    check("clr_ba1ba3", ba1ba3, 0);
    check("clr_ba1ba2ba3", ba1ba2ba3, 0);
    check("clr_iter_count", iter_count, 0);
    check("clr_in_ready", in_ready, 1'b1);
    @(negedge Clock);
    check("clr_no_stale", out_valid, 1'b0);
    out_ready = 1'b1;

    // Iteration wrap and frame_done.
    for (int i = 1; i <= 8; i++) begin
      pulse_iter();
      check("wrap_count", iter_count, i % 8);
      check("wrap_frame_done", frame_done, (i == 8));
    end
    @(negedge Clock);
    check("frame_done_single", frame_done, 1'b0);

    // Asynchronous reset mid-stream.
    pulse_iter();
    pulse_iter();
    fill_two();
    check("mid_pre_valid", out_valid, 1'b1);
    #2; nReset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ba2", ba2, 0);
    check("mid_rst_ba1ba3", ba1ba3, 0);
    check("mid_rst_iter", iter_count, 0);
    check("mid_rst_ready", in_ready, 1'b1);
    @(negedge Clock); nReset = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      check("post_rst_no_valid", out_valid, 1'b0);
    end
    push(20, 10, -7, 1'b0);
    check("post_rst_ba1ba3", ba1ba3, -7);
    check("post_rst_sum", ba1ba2ba3, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
